// File: rtl/md_pkg.sv
// md_pkg: shared types and constants for the market-data trade decoder.
//   dec_state_t  - decoder FSM states (HDR0, HDR1, ENTRY, DRAIN)
//   HDR_BYTES    - bytes in a message header (count + reserved)
//   ENTRY_BYTES  - bytes per trade entry
//   AGG_*        - aggressor side encodings driven on aggressor_side
//   trade_t      - one decoded trade record
//   unpack_entry - turns a complete little-endian entry into a trade_t
package md_pkg;

  localparam int HDR_BYTES   = 2;
  localparam int ENTRY_BYTES = 17;

  localparam logic [1:0] AGG_NONE = 2'd0;
  localparam logic [1:0] AGG_BUY  = 2'd1;
  localparam logic [1:0] AGG_SELL = 2'd2;

  typedef enum logic [1:0] {
    HDR0,
    HDR1,
    ENTRY,
    DRAIN
  } dec_state_t;

  typedef struct packed {
    logic [31:0] security_id;
    logic [63:0] price;
    logic [31:0] size;
    logic [1:0]  aggressor_side;
  } trade_t;

  // Unknown aggressor codes are reported as "no aggressor" rather than rejected.
  function automatic logic [1:0] decode_aggressor(input logic [7:0] b);
    case (b)
      8'd1:    return AGG_BUY;
      8'd2:    return AGG_SELL;
      default: return AGG_NONE;
    endcase
  endfunction

  // Entry byte k sits at bits [8k+7:8k]: price 0-7, size 8-11, id 12-15, aggressor 16.
  function automatic trade_t unpack_entry(input logic [ENTRY_BYTES*8-1:0] w);
    trade_t t;
    t.price          = w[63:0];
    t.size           = w[95:64];
    t.security_id    = w[127:96];
    t.aggressor_side = decode_aggressor(w[135:128]);
    return t;
  endfunction

endpackage

// File: rtl/md_le_field_shift.sv
// md_le_field_shift: little-endian staging shifter for one trade entry.
//   clk, rst       - clock and asynchronous active-low reset
//   shift_en_i     - accept byte_i into the staging window
//   clear_i        - drop any partially staged entry
//   byte_i         - incoming stream byte
//   word_o         - NBYTES-byte window, byte_i in the top lane and the
//                    oldest staged byte in the bottom lane
// Only NBYTES-1 bytes are registered; the final byte of an entry is taken live
// from byte_i so the complete entry is visible in the cycle that accepts it.
module md_le_field_shift #(
  parameter int NBYTES = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  shift_en_i,
  input  logic                  clear_i,
  input  logic [7:0]            byte_i,
  output logic [NBYTES*8-1:0]   word_o
);

  logic [(NBYTES-1)*8-1:0] stage_q;
  logic [(NBYTES-1)*8-1:0] stage_d;

  assign word_o = {byte_i, stage_q};

  // New bytes enter at the top and older bytes move down, so after a full
  // entry the first byte received ends up in the lowest lane.
  always_comb begin
    stage_d = stage_q;
    if (clear_i) begin
      stage_d = '0;
    end else if (shift_en_i) begin
      stage_d = word_o[NBYTES*8-1:8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

endmodule

// File: rtl/md_trade_decoder.sv
// md_trade_decoder: parses framed trade-summary messages into trade records.
//   clk, rst        - clock and asynchronous active-low reset
//   in_data/in_valid/in_last/in_ready - byte stream input (one byte per cycle)
//   security_id, price, size, aggressor_side - last decoded trade (held)
//   valid           - one-cycle pulse per decoded entry
//   err_count       - saturating count of malformed messages
//   entry_count     - wrapping count of decoded entries when
//                     MD_TRADE_DECODER_STATS_EN is defined, otherwise 0
// Message: count byte N, reserved byte, then N 17-byte little-endian entries.
module md_trade_decoder
  import md_pkg::*;
#(
  parameter int unsigned MAX_ENTRIES = 31
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] security_id,
  output logic [63:0] price,
  output logic [31:0] size,
  output logic [1:0]  aggressor_side,
  output logic        valid,
  output logic [15:0] err_count,
  output logic [31:0] entry_count
);

  dec_state_t  state_q, state_d;
  logic [4:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  remaining_q, remaining_d;
  logic [7:0]  n_q, n_d;
  logic        in_ready_q;
  trade_t      trade_q;
  logic        valid_q;
  logic [15:0] err_count_q;

  logic        accept;
  logic        err_evt;
  logic        load_evt;
  logic        shift_en;
  logic        clear_stage;
  logic [ENTRY_BYTES*8-1:0] entry_word;

  assign accept = in_valid && in_ready_q;

  md_le_field_shift #(
    .NBYTES (ENTRY_BYTES)
  ) u_stage (
    .clk        (clk),
    .rst        (rst),
    .shift_en_i (shift_en),
    .clear_i    (clear_stage),
    .byte_i     (in_data),
    .word_o     (entry_word)
  );

  // Next-state logic. Nothing moves without an accepted byte, so input bubbles
  // freeze byte_idx and remaining. Every error either ends the message or sends
  // it to DRAIN, which is why a message can raise at most one error.
  always_comb begin
    state_d     = state_q;
    byte_idx_d  = byte_idx_q;
    remaining_d = remaining_q;
    n_d         = n_q;
    err_evt     = 1'b0;
    load_evt    = 1'b0;
    shift_en    = 1'b0;
    clear_stage = 1'b0;
    if (accept) begin
      case (state_q)
        HDR0: begin
          n_d = in_data;
          if (in_last) begin
            err_evt = 1'b1;
            state_d = HDR0;
          end else if (32'(in_data) > MAX_ENTRIES) begin
            err_evt = 1'b1;
            state_d = DRAIN;
          end else begin
            state_d = HDR1;
          end
        end
        HDR1: begin
          if (n_q == 8'd0) begin
            err_evt = !in_last;
            state_d = HDR0;
          end else if (in_last) begin
            err_evt = 1'b1;
            state_d = HDR0;
          end else begin
            byte_idx_d  = 5'd0;
            remaining_d = n_q;
            state_d     = ENTRY;
          end
        end
        ENTRY: begin
          if (byte_idx_q == 5'(ENTRY_BYTES - 1)) begin
            load_evt    = 1'b1;
            shift_en    = 1'b1;
            byte_idx_d  = 5'd0;
            remaining_d = remaining_q - 8'd1;
            if (remaining_q == 8'd1) begin
              err_evt = !in_last;
              state_d = in_last ? HDR0 : DRAIN;
            end else if (in_last) begin
              err_evt = 1'b1;
              state_d = HDR0;
            end
          end else if (in_last) begin
            clear_stage = 1'b1;
            err_evt     = 1'b1;
            state_d     = HDR0;
          end else begin
            shift_en   = 1'b1;
            byte_idx_d = byte_idx_q + 5'd1;
          end
        end
        DRAIN: begin
          if (in_last) begin
            state_d = HDR0;
          end
        end
        default: state_d = HDR0;
      endcase
    end
  end

  // FSM and header bookkeeping registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= HDR0;
      byte_idx_q  <= 5'd0;
      remaining_q <= 8'd0;
      n_q         <= 8'd0;
    end else begin
      state_q     <= state_d;
      byte_idx_q  <= byte_idx_d;
      remaining_q <= remaining_d;
      n_q         <= n_d;
    end
  end

  // Output side: fields only change on a completed entry, valid is a single
  // cycle pulse, and in_ready comes up one edge after reset and stays up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready_q  <= 1'b0;
      trade_q     <= '0;
      valid_q     <= 1'b0;
      err_count_q <= 16'd0;
    end else begin
      in_ready_q <= 1'b1;
      valid_q    <= load_evt;
      if (load_evt) begin
        trade_q <= unpack_entry(entry_word);
      end
      if (err_evt && (err_count_q != 16'hFFFF)) begin
        err_count_q <= err_count_q + 16'd1;
      end
    end
  end

`ifdef MD_TRADE_DECODER_STATS_EN
  logic [31:0] entry_count_q;

  // Counts entries as they are committed; wraps naturally at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_count_q <= 32'd0;
    end else if (load_evt) begin
      entry_count_q <= entry_count_q + 32'd1;
    end
  end

  assign entry_count = entry_count_q;
`else
  assign entry_count = 32'd0;
`endif

  assign in_ready       = in_ready_q;
  assign security_id    = trade_q.security_id;
  assign price          = trade_q.price;
  assign size           = trade_q.size;
  assign aggressor_side = trade_q.aggressor_side;
  assign valid          = valid_q;
  assign err_count      = err_count_q;

endmodule

// File: tb/tb_md_trade_decoder.sv
// tb_md_trade_decoder: self-checking bench for md_trade_decoder.
// Builds whole messages as byte queues, derives the expected trades and error
// counts from the message layout rules, and compares against what the decoder
// emits. Honours MD_TRADE_DECODER_STATS_EN for the entry_count checks.
module tb_md_trade_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [31:0] security_id;
  logic [63:0] price;
  logic [31:0] size;
  logic [1:0]  aggressor_side;
  logic        valid;
  logic [15:0] err_count;
  logic [31:0] entry_count;

  md_trade_decoder dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .security_id    (security_id),
    .price          (price),
    .size           (size),
    .aggressor_side (aggressor_side),
    .valid          (valid),
    .err_count      (err_count),
    .entry_count    (entry_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] sid;
    logic [63:0] price;
    logic [31:0] size;
    logic [1:0]  agg;
  } trade_rec_t;

  typedef struct {
    int         n;
    int         len;
    int         extra;
    logic [7:0] agg;
    int         expPulses;
    int         expErrDelta;
    logic [1:0] expAgg;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          pulseTotal = 0;
  int          expErr = 0;
  int          expPulsesSinceReset = 0;
  logic        prevValid = 1'b0;
  trade_rec_t  lastExp = '0;
  trade_rec_t  obsQ[$];
  trade_rec_t  expQ[$];
  logic [7:0]  msg[$];
  vec_t        vecs[12];

  task automatic checkOutput(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Watches every valid pulse: records the trade and checks it was preceded by a low cycle.
  always @(negedge clk) begin
    if (!rst) begin
      prevValid = 1'b0;
    end else begin
      if (valid) begin
        checkOutput("valid_gap", 192'(prevValid), 192'd0);
        obsQ.push_back(trade_rec_t'{security_id, price, size, aggressor_side});
        pulseTotal++;
      end
      prevValid = valid;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle(input int k);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (k) @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic last, input bit gaps);
    int guard;
    int g;
    if (gaps) begin
      g = $urandom_range(0, 3);
      in_valid = 1'b0;
      repeat (g) @(negedge clk);
    end
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL in_ready_wait: got 0 expected 1");
    end
    @(negedge clk);
  endtask

  task automatic sendMsg(input bit gaps);
    for (int i = 0; i < msg.size(); i++) begin
      applyStimulus(msg[i], (i == msg.size() - 1), gaps);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic addEntry(input logic [63:0] p, input logic [31:0] s, input logic [31:0] id, input logic [7:0] a);
    for (int i = 0; i < 8; i++) msg.push_back(p[8*i +: 8]);
    for (int i = 0; i < 4; i++) msg.push_back(s[8*i +: 8]);
    for (int i = 0; i < 4; i++) msg.push_back(id[8*i +: 8]);
    msg.push_back(a);
  endtask

  function automatic logic [63:0] genPrice(input int k);
    return {32'hA5A50000 + 32'(k), 32'h00001000 + 32'(3 * k)};
  endfunction

  function automatic logic [1:0] aggRule(input logic [7:0] b);
    if (b == 8'd1) return 2'd1;
    if (b == 8'd2) return 2'd2;
    return 2'd0;
  endfunction

  // Message-level reference: a message yields as many trades as it has complete
  // entries (capped by N) and is in error whenever its length is not 2+17*N.
  task automatic modelMsg();
    int L;
    int n;
    int full;
    int base;
    trade_rec_t t;
    L = msg.size();
    n = int'(msg[0]);
    if (L == 1 || n > 31) begin
      expErr++;
      return;
    end
    if (n == 0) begin
      if (L != 2) expErr++;
      return;
    end
    full = (L - 2) / 17;
    if (full > n) full = n;
    for (int e = 0; e < full; e++) begin
      base = 2 + 17 * e;
      for (int k = 0; k < 8; k++) t.price[8*k +: 8] = msg[base + k];
      for (int k = 0; k < 4; k++) t.size[8*k +: 8] = msg[base + 8 + k];
      for (int k = 0; k < 4; k++) t.sid[8*k +: 8] = msg[base + 12 + k];
      t.agg = aggRule(msg[base + 16]);
      expQ.push_back(t);
      expPulsesSinceReset++;
    end
    if (L != 2 + 17 * n) expErr++;
  endtask

  task automatic addRandEntry();
    logic [7:0] a;
    case ($urandom_range(0, 3))
      0:       a = 8'd1;
      1:       a = 8'd2;
      2:       a = 8'd0;
      default: a = 8'($urandom);
    endcase
    for (int i = 0; i < 16; i++) msg.push_back(8'($urandom));
    msg.push_back(a);
  endtask

  task automatic buildRandomMsg(input int kind);
    int n;
    int cut;
    msg.delete();
    if (kind <= 5) begin
      n = $urandom_range(0, 3);
      msg.push_back(8'(n));
      msg.push_back(8'($urandom));
      for (int e = 0; e < n; e++) addRandEntry();
    end else if (kind == 6) begin
      n = $urandom_range(1, 3);
      msg.push_back(8'(n));
      msg.push_back(8'($urandom));
      for (int e = 0; e < n; e++) addRandEntry();
      cut = $urandom_range(3, msg.size() - 1);
      while (msg.size() > cut) void'(msg.pop_back());
    end else if (kind == 7) begin
      n = $urandom_range(1, 2);
      msg.push_back(8'(n));
      msg.push_back(8'($urandom));
      for (int e = 0; e < n; e++) addRandEntry();
      repeat ($urandom_range(1, 6)) msg.push_back(8'($urandom));
    end else if (kind == 8) begin
      msg.push_back(8'($urandom_range(32, 255)));
      msg.push_back(8'($urandom));
      repeat ($urandom_range(0, 20)) msg.push_back(8'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        while (msg.size() > 1) void'(msg.pop_back());
      end
    end else begin
      msg.push_back(8'($urandom_range(0, 31)));
    end
  endtask

  initial begin
    trade_rec_t single;
    int p0;
    int k;
    int m;

    vecs[0]  = '{1,  -1, 0, 8'd1,   1,  0, 2'd1};
    vecs[1]  = '{2,  -1, 0, 8'd2,   2,  0, 2'd2};
    vecs[2]  = '{0,  -1, 0, 8'd1,   0,  0, 2'd0};
    vecs[3]  = '{1,  12, 0, 8'd1,   0,  1, 2'd0};
    vecs[4]  = '{1,  -1, 5, 8'd2,   1,  1, 2'd2};
    vecs[5]  = '{32, 25, 0, 8'd1,   0,  1, 2'd0};
    vecs[6]  = '{1,  -1, 0, 8'd7,   1,  0, 2'd0};
    vecs[7]  = '{3,  36, 0, 8'd1,   2,  1, 2'd1};
    vecs[8]  = '{1,  -1, 0, 8'hFF,  1,  0, 2'd0};
    vecs[9]  = '{1,   1, 0, 8'd1,   0,  1, 2'd0};
    vecs[10] = '{2,   2, 0, 8'd1,   0,  1, 2'd0};
    vecs[11] = '{31, -1, 0, 8'd2,  31,  0, 2'd2};

    // Reset state, then in_ready rising one edge after release.
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_outputs",
                {security_id, price, size, aggressor_side, valid, err_count, entry_count},
                192'd0);
    checkOutput("reset_in_ready", 192'(in_ready), 192'd0);
    rst = 1'b1;
    #1;
    checkOutput("in_ready_before_edge", 192'(in_ready), 192'd0);
    @(negedge clk);
    #1;
    checkOutput("in_ready_after_edge", 192'(in_ready), 192'd1);

    // Single entry with exact pulse timing.
    msg.delete();
    msg.push_back(8'd1);
    msg.push_back(8'h00);
    addEntry(64'h0000000000002710, 32'd5, 32'h00001234, 8'd1);
    for (int i = 0; i < 18; i++) applyStimulus(msg[i], 1'b0, 1'b0);
    checkOutput("single_no_early_valid", 192'(valid), 192'd0);
    applyStimulus(msg[18], 1'b1, 1'b0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    single = '{32'h1234, 64'd10000, 32'd5, 2'd1};
    checkOutput("single_valid", 192'(valid), 192'd1);
    checkOutput("single_fields", {security_id, price, size, aggressor_side}, 192'(single));
    @(negedge clk);
    #1;
    checkOutput("single_valid_drop", 192'(valid), 192'd0);
    checkOutput("single_err", 192'(err_count), 192'd0);
    lastExp = single;
    expPulsesSinceReset = 1;

    // Table-driven message cases.
    for (int v = 0; v < 12; v++) begin
      msg.delete();
      msg.push_back(8'(vecs[v].n));
      msg.push_back(8'hEE);
      m = (vecs[v].n > 31) ? 2 : vecs[v].n;
      for (int e = 0; e < m; e++) begin
        k = v * 40 + e;
        addEntry(genPrice(k), 32'(100 + k), 32'h1000 + 32'(k), vecs[v].agg);
      end
      repeat (vecs[v].extra) msg.push_back(8'h5A);
      if (vecs[v].len >= 0) begin
        while (msg.size() > vecs[v].len) void'(msg.pop_back());
      end
      p0 = pulseTotal;
      sendMsg(v % 2 == 1);
      idle(4);
      checkOutput($sformatf("vec%0d_pulses", v), 192'(pulseTotal - p0), 192'(vecs[v].expPulses));
      expErr += vecs[v].expErrDelta;
      expPulsesSinceReset += vecs[v].expPulses;
      checkOutput($sformatf("vec%0d_err", v), 192'(err_count), 192'(expErr));
      if (vecs[v].expPulses > 0) begin
        k = v * 40 + vecs[v].expPulses - 1;
        lastExp = '{32'h1000 + 32'(k), genPrice(k), 32'(100 + k), vecs[v].expAgg};
      end
      checkOutput($sformatf("vec%0d_fields", v), {security_id, price, size, aggressor_side}, 192'(lastExp));
    end

    // Reset in the middle of an entry.
    msg.delete();
    msg.push_back(8'd1);
    msg.push_back(8'd0);
    addEntry(64'hFFFF_FFFF_FFFF_FF00, 32'd77, 32'hCAFE0001, 8'd2);
    for (int i = 0; i < 12; i++) applyStimulus(msg[i], 1'b0, 1'b0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("midreset_outputs",
                {security_id, price, size, aggressor_side, valid, err_count, entry_count},
                192'd0);
    checkOutput("midreset_in_ready", 192'(in_ready), 192'd0);
    expErr = 0;
    expPulsesSinceReset = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    p0 = pulseTotal;
    sendMsg(1'b0);
    idle(3);
    expPulsesSinceReset = 1;
    checkOutput("postreset_pulses", 192'(pulseTotal - p0), 192'd1);
    checkOutput("postreset_fields", {security_id, price, size, aggressor_side},
                192'(trade_rec_t'{32'hCAFE0001, 64'hFFFF_FFFF_FFFF_FF00, 32'd77, 2'd2}));
    checkOutput("postreset_err", 192'(err_count), 192'd0);

    // Randomized messages against the message-level model.
    obsQ.delete();
    expQ.delete();
    for (int i = 0; i < 3; i++) begin
      msg.delete();
      msg.push_back(8'd2);
      msg.push_back(8'($urandom));
      addRandEntry();
      addRandEntry();
      modelMsg();
      sendMsg(1'b1);
    end
    for (int i = 0; i < 40; i++) begin
      buildRandomMsg($urandom_range(0, 9));
      modelMsg();
      sendMsg(($urandom_range(0, 1) == 1));
    end
    idle(5);
    checkOutput("rand_trade_count", 192'(obsQ.size()), 192'(expQ.size()));
    for (int i = 0; i < obsQ.size() && i < expQ.size(); i++) begin
      checkOutput($sformatf("rand_trade%0d", i), 192'(obsQ[i]), 192'(expQ[i]));
    end
    checkOutput("rand_err", 192'(err_count), 192'(expErr));
`ifdef MD_TRADE_DECODER_STATS_EN
    checkOutput("entry_count", 192'(entry_count), 192'(expPulsesSinceReset));
`else
    checkOutput("entry_count_tied", 192'(entry_count), 192'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_trade_decoder.md
# md_trade_decoder

Parses the framed binary trade-summary byte stream from the market-data feed handler into one trade record per entry. Drives the trade inputs of the per-instrument trigger bank: security_id, price, size, aggressor_side and a single-cycle valid pulse. It is the producer end of the trade interface the triggers consume. It has no output backpressure, so it accepts one byte per cycle at line rate.

## Interface
- MAX_ENTRIES, 31: maximum legal entry count per message; larger header counts are a protocol error.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data valid.
- in_last  in  1  final byte of message, qualified by in_valid.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- security_id  out  32  decoded security id.
- price  out  64  decoded price, two's-complement fixed point, passed through unscaled.
- size  out  32  decoded size.
- aggressor_side  out  2  0 none, 1 buy, 2 sell.
- valid  out  1  one-cycle pulse per decoded entry.
- err_count  out  16  saturating protocol-error count.
- entry_count  out  32  wrapping decoded-entry count; driven 0 unless MD_TRADE_DECODER_STATS_EN.

## Operation
- Message layout: byte 0 is entry count N; byte 1 is reserved and ignored; then N entries of 17 bytes each.
- Entry layout, little-endian: price bytes 0-7, size bytes 8-11, security_id bytes 12-15, aggressor byte 16.
- Aggressor byte 1→1, 2→2; any other value→0.
- FSM states: HDR0, HDR1, ENTRY, DRAIN. Reset state is HDR0.
- HDR0: latch N. Then go to HDR1.
- HDR1: if N==0, in_last must be set on this byte; go to HDR0. Otherwise go to ENTRY with byte_idx=0 and remaining=N.
- ENTRY: shift each byte into a staging register; byte_idx counts 0..16.
- On byte 16: load the output fields from staging, pulse valid, decrement remaining.
  - remaining reaches 0 with in_last set → HDR0.
  - remaining reaches 0 without in_last → DRAIN, with an error.
  - in_last set while remaining is still nonzero → HDR0, with an error.
- Truncation: in_last on any ENTRY byte before 16 → discard the partial entry, no valid pulse, error, go to HDR0.
- N > MAX_ENTRIES on HDR0 → error, go to DRAIN (or to HDR0 if in_last is set on that byte).
- Missing last byte: in_last on HDR0, or in_last on HDR1 with N≠0 → error, go to HDR0.
- DRAIN: discard bytes until an in_last byte, then go to HDR0.
- Errors increment err_count by 1 per message and saturate at 0xFFFF.
- Output fields hold their last decoded entry until the next valid pulse. Partial entries never update them.

## Timing
- Reset values:
  - in_ready=0; FSM in HDR0.
  - security_id, price, size, aggressor_side, valid, err_count, entry_count all 0.
- in_ready rises on the first clk edge after rst deasserts, then stays 1.
- Latency: valid and the fields are registered one cycle after the clock edge that accepts entry byte 16.
- valid is high exactly one cycle. Consecutive pulses are at least 17 cycles apart, so valid always returns low between entries (consumers edge-detect it).
- Bubbles: in_valid low stalls all state; byte_idx and remaining hold.
- rst asserted mid-message: everything returns to reset values immediately and the partial entry is lost. After rst releases, decoding restarts at HDR0, so the next byte is treated as a header.

## Configuration
- MD_TRADE_DECODER_STATS_EN defined: entry_count increments by 1 on each valid pulse and wraps at 2^32.
- MD_TRADE_DECODER_STATS_EN undefined: entry_count is tied to 0 and the counter is not built. err_count is always present.

## Structure
- Shared package md_pkg holds:
  - dec_state_t enum (HDR0, HDR1, ENTRY, DRAIN);
  - constants HDR_BYTES=2 and ENTRY_BYTES=17;
  - aggressor encodings AGG_NONE/AGG_BUY/AGG_SELL;
  - packed trade_t struct (security_id, price, size, aggressor_side).
- One sub-module, md_le_field_shift: a 17-byte little-endian staging shifter with load-enable and clear, instanced once.

## Test plan
- Single-entry message: N=1, price 0x0000000000002710, size 5, security_id 0x1234, aggressor 1 → exactly one valid pulse 1 cycle after byte 18, with price=10000, size=5, security_id=0x1234, aggressor_side=1, err_count=0.
- Back-to-back: three messages with N=2, with random in_valid gaps → 6 pulses in order, each separated by low cycles, fields matching. With STATS_EN, entry_count=6.
- Truncation: in_last on entry byte 9 → no pulse, previous fields unchanged, err_count=1. A following good message decodes correctly.
- Overrun: N=1 followed by 5 extra bytes then in_last → one pulse, then DRAIN, err_count=1, next header parsed correctly.
- Edge cases:
  - N=0 with in_last on byte 1 → no pulse, no error.
  - N=32 → error, drained.
  - aggressor byte 7 → aggressor_side=0.
- Reset mid-entry at byte 10 → outputs 0 and in_ready 0 immediately. After release, the next message decodes correctly from its header.
